core_exu_wb_arb: RTL
====================

Name: core_exu_wb_arb

Overview:
- Shares the single register-file write port among the execute sub-units: logic unit, ALU, shifter, load unit.
- Each sub-unit presents a result with a valid/ready handshake. The block grants one per cycle, round-robin.
- The granted result goes into a registered writeback stage that drives the regfile write port.
- Sits between the EXU sub-units and the regfile; also exports a contention counter for performance monitoring.

Parameters:
- NUM_REQ, 4, number of requesters (2..8); index 0 = logic unit, 1 = ALU, 2 = shifter, 3 = load.
- DATA_W, 32, result width.
- CNT_W, 32, contention counter width.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester result valid.
- req_rd  input  5*NUM_REQ  destination register; slice i = [5*i+:5].
- req_data  input  DATA_W*NUM_REQ  result; slice i = [DATA_W*i+:DATA_W].
- req_ready  output  NUM_REQ  one-hot grant, combinational.
- wb_stall  input  1  downstream stall; no grants while high.
- flush  input  1  pipeline flush; squashes the writeback stage.
- wb_en  output  1  regfile write enable, registered.
- wb_rd  output  5  regfile write address, registered.
- wb_data  output  DATA_W  regfile write data, registered.
- contention_cnt  output  CNT_W  cycles with more than one req_valid asserted, saturating.
- cnt_clr  input  1  synchronous clear of contention_cnt.

Behaviour:
- Reset (rst_n low, async): wb_en=0, wb_rd=0, wb_data=0, rr_ptr=0, contention_cnt=0. req_ready is 0 whenever rst_n is low.
- Handshake:
  - A transfer occurs on requester i when req_valid[i] & req_ready[i] at a clock edge.
  - A requester holds valid, rd and data stable until it is granted; the arbiter never drops an asserted request.
  - req_ready never depends on req_data.
- Grant, combinational:
  - If flush or wb_stall is high, req_ready=0.
  - Otherwise search req_valid starting at index rr_ptr, ascending and wrapping; the first set bit gets req_ready.
  - At most one bit is set. All zero if no valid.
- Pointer:
  - On a transfer by i, rr_ptr <= (i+1) mod NUM_REQ. Wraparound at NUM_REQ-1 returns to 0.
  - No transfer: rr_ptr holds.
- Writeback stage, 1-cycle latency: a transfer at edge N appears on wb_en/wb_rd/wb_data during cycle N+1.
  - Transfer with rd!=0: wb_en<=1, wb_rd<=req_rd[i], wb_data<=req_data[i].
  - Transfer with rd==0: handshake completes and pointer advances, but wb_en<=0 (x0 is never written); wb_rd/wb_data still load.
  - No transfer and wb_stall=0: wb_en<=0; wb_rd/wb_data hold.
  - wb_stall=1 and flush=0: wb_en, wb_rd, wb_data all hold.
  - flush=1: wb_en<=0, pointer holds. Flush has priority over stall.
- Contention counter:
  - Increments when popcount(req_valid)>=2, regardless of stall or flush.
  - Saturates at all-ones.
  - cnt_clr=1 sets it to 0. Clear has priority over increment.
- Reset mid-operation clears the writeback stage immediately. In-flight requesters simply re-present after reset.

Optional Feature:
- Macro: CORE_WB_FIXED_PRIO_EN.
- Defined: round-robin is replaced by fixed priority, lowest index wins (logic unit highest). rr_ptr is not implemented; all other behaviour is unchanged.
- Undefined: round-robin as above.

Test Plan:
- Single request: after reset, req_valid=4'b0010, rd=5, data=32'hDEADBEEF. Expect req_ready=4'b0010 the same cycle; next cycle wb_en=1, wb_rd=5, wb_data=32'hDEADBEEF; rr_ptr=2.
- Round-robin: all 4 valid held for 4 cycles, each requester dropping valid after its own grant. Grant order 0,1,2,3; contention_cnt=3. With CORE_WB_FIXED_PRIO_EN the order is also 0,1,2,3. With requesters 0 and 1 permanently valid and the macro defined: grants 0,0,0; without it: 0,1,0.
- x0 suppression: requester 2 valid with rd=0, data=32'h1234. Expect req_ready[2]=1, next cycle wb_en=0, rr_ptr=3.
- Stall: a transfer writes rd=7; wb_stall asserted 3 cycles with requester 3 valid. Expect req_ready=0 and wb_en=1, wb_rd=7 held for those 3 cycles. After release, requester 3 is granted and its result appears next cycle.
- Flush with stall: flush=1 and wb_stall=1 while wb_en=1. Next cycle wb_en=0; no grant; rr_ptr unchanged.
- Counter saturation: CNT_W=4, two requesters valid for 20 cycles. Expect contention_cnt=4'hF. Then cnt_clr together with contention: counter = 0. Async reset mid-burst: all outputs 0 immediately.

Source files
------------

// File: rtl/core_exu_wb_arb.sv
// Writeback arbiter: shares the regfile write port among EXU sub-units, round-robin by default.
// Define CORE_WB_FIXED_PRIO_EN for fixed priority (lowest index wins, no rotating pointer).
module core_exu_wb_arb #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [5*NUM_REQ-1:0]       req_rd,
    input  logic [DATA_W*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       wb_stall,
    input  logic                       flush,
    output logic                       wb_en,
    output logic [4:0]                 wb_rd,
    output logic [DATA_W-1:0]          wb_data,
    output logic [CNT_W-1:0]           contention_cnt,
    input  logic                       cnt_clr
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic              grant_en;
    logic              gnt_any;
    logic [IDX_W-1:0]  gnt_idx;
    logic [IDX_W-1:0]  cand;
    logic [4:0]        sel_rd;
    logic [DATA_W-1:0] sel_data;
    int unsigned       valid_cnt;
    logic              multi_valid;

    assign grant_en = rst_n & ~flush & ~wb_stall;

`ifdef CORE_WB_FIXED_PRIO_EN
    always_comb begin
        req_ready = '0;
        gnt_idx   = '0;
        gnt_any   = 1'b0;
        cand      = '0;
        if (grant_en) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                cand = IDX_W'(k);
                if (!gnt_any && req_valid[cand]) begin
                    gnt_any         = 1'b1;
                    gnt_idx         = cand;
                    req_ready[cand] = 1'b1;
                end
            end
        end
    end
`else
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    int unsigned      pos;

    // Search starts at rr_ptr and wraps, so the most recent winner goes last.
    always_comb begin
        req_ready = '0;
        gnt_idx   = '0;
        gnt_any   = 1'b0;
        cand      = '0;
        pos       = 0;
        if (grant_en) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                pos = 32'(rr_ptr_q) + k;
                if (pos >= NUM_REQ) begin
                    pos = pos - NUM_REQ;
                end
                cand = IDX_W'(pos);
                if (!gnt_any && req_valid[cand]) begin
                    gnt_any         = 1'b1;
                    gnt_idx         = cand;
                    req_ready[cand] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_any) begin
            rr_ptr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    // One-hot grant makes an AND-OR mux sufficient.
    always_comb begin
        sel_rd    = '0;
        sel_data  = '0;
        valid_cnt = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            sel_rd   = sel_rd | (req_rd[5*k +: 5] & {5{req_ready[k]}});
            sel_data = sel_data | (req_data[DATA_W*k +: DATA_W] & {DATA_W{req_ready[k]}});
            if (req_valid[k]) begin
                valid_cnt = valid_cnt + 1;
            end
        end
    end

    assign multi_valid = (valid_cnt >= 2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_en   <= 1'b0;
            wb_rd   <= '0;
            wb_data <= '0;
        end else if (flush) begin
            wb_en <= 1'b0;
        end else if (!wb_stall) begin
            if (gnt_any) begin
                wb_en   <= (sel_rd != 5'd0);
                wb_rd   <= sel_rd;
                wb_data <= sel_data;
            end else begin
                wb_en <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            contention_cnt <= '0;
        end else if (cnt_clr) begin
            contention_cnt <= '0;
        end else if (multi_valid && (contention_cnt != {CNT_W{1'b1}})) begin
            contention_cnt <= contention_cnt + 1'b1;
        end
    end

endmodule
